data_mem_arbiter: RTL
=====================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the single synchronous data-memory port between two masters: m0 = cpu_core data port,
//  m1 = debug/loader master (program/data preload, result readback). Sits between both masters
//  and the data RAM (1-cycle read latency, byte-enabled writes). Provides round-robin arbitration,
//  a bounded lock for atomic sequences and per-master read-response routing.
// PARAMETERS
//  ADDR_W    32  address width, byte address
//  DATA_W    32  data width; byte-enable width = DATA_W/8
//  MAX_HOLD  4   max consecutive locked grants to one master while the other requests (>=1)
// PORTS
//  clk        in   1         clock, all logic on posedge
//  rst        in   1         synchronous reset, active-high
//  mN_req     in   1         N in {0,1}: request valid; addr/wdata/we/be/lock stable while req&!gnt
//  mN_addr    in   ADDR_W    request address
//  mN_wdata   in   DATA_W    write data
//  mN_we      in   1         1=write, 0=read
//  mN_be      in   DATA_W/8  byte enables (writes only)
//  mN_lock    in   1         request that mN keep ownership after this transfer
//  mN_gnt     out  1         request accepted this cycle (combinational from req/state)
//  mN_rvalid  out  1         read data valid for mN
//  mN_rdata   out  DATA_W    read data; mem_rdata when mN_rvalid, else 0
//  mem_addr   out  ADDR_W    to RAM: granted master's addr, else 0
//  mem_wdata  out  DATA_W    granted master's wdata, else 0
//  mem_we     out  1         granted & we
//  mem_be     out  DATA_W/8  granted ? be : 0
//  mem_rdata  in   DATA_W    RAM read data, valid 1 cycle after address
// BEHAVIOUR
//  - Transfer = mN_req & mN_gnt. At most one gnt per cycle. gnt never asserted without req.
//  - States: ARB, LOCK0, LOCK1. Regs: last_gnt (1b), hold_cnt ($clog2(MAX_HOLD+1)b), resp_v, resp_id.
//  - ARB: one req -> grant it. Both -> grant !last_gnt. last_gnt <= granted id on every transfer.
//    Transfer with mN_lock=1 -> LOCKN, hold_cnt <= 0.
//  - LOCKN: only mN may be granted; other master stalls. Per mN transfer while other req:
//    hold_cnt++. Exit to ARB when: mN transfer with lock=0; or mN_req=0; or hold_cnt reaches
//    MAX_HOLD (forced exit; last_gnt <= N so other master wins next tie). Exit resets hold_cnt.
//  - Forced exit ignores mN_lock; mN re-arbitrates in ARB normally.
//  - Read response: read transfer at cycle t -> resp_v=1, resp_id=N at t+1; mN_rvalid=1 at t+1
//    only, mN_rdata=mem_rdata. Writes produce no rvalid. Back-to-back reads: one rvalid per cycle,
//    routed per-transfer (m0 read t, m1 read t+1 -> m0_rvalid t+1, m1_rvalid t+2).
//  - we=1 with be=0: legal no-op write, granted and counted normally.
//  - No transfer: mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
//  - Reset (any cycle, incl. mid-lock or with read outstanding): state=ARB, last_gnt=1 (m0 wins
//    first tie), hold_cnt=0, resp_v=0; all gnt/rvalid/mem_we = 0 during rst; pending rvalid dropped.
//  - Throughput: 1 transfer/cycle; zero added latency on request path, 1 cycle on read path.
// STRUCTURE
//  - Package data_mem_arb_pkg: typedef enum logic [1:0] {ARB, LOCK0, LOCK1} arb_state_t;
//    localparam M_CPU=1'b0, M_DBG=1'b1.
//  - One sub-module: arb_rr_pick2 (combinational: req[1:0], last_gnt, state -> gnt[1:0]).
//  - Top holds state/hold_cnt/last_gnt/resp regs and mem mux.
// TESTING
//  - Reset 5 cycles, m0 read 0x10 (RAM=0xDEADBEEF) -> m0_gnt same cycle, m0_rvalid next, data ok, m1_rvalid=0.
//  - m0,m1 req every cycle, no lock -> grants alternate m0,m1,m0,m1; first grant m0 after reset.
//  - m1 writes 0xA5 to 0x20 be=0001 then m0 reads 0x20 -> m0_rdata[7:0]=0xA5, other bytes unchanged.
//  - m1 lock=1, m0 req continuously, MAX_HOLD=4 -> m1 gets exactly 4 grants, then m0 granted next cycle.
//  - Back-to-back m0 read 0x0 then m1 read 0x4 -> m0_rvalid t+1 with mem[0], m1_rvalid t+2 with mem[1].
//  - rst asserted cycle after m0 read accepted -> m0_rvalid stays 0; state ARB; next tie grants m0.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : arbitration state (free arbitration, or locked to m0 / m1)
//   M_CPU/M_DBG : master ids, also used as the bit index into the 2-bit req/gnt vectors
package data_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_pick2.sv
// Combinational two-way grant picker.
//   req      in  [1:0]  request vector, bit N = master N (already masked during reset)
//   last_gnt in         id of the master that won the most recent transfer
//   state    in         arbitration state; a locked state restricts the grant to its owner
//   gnt      out [1:0]  one-hot or zero grant vector, never set without the matching req
module arb_rr_pick2
    import data_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  arb_state_t state,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (state)
            LOCK0: gnt[M_CPU] = req[M_CPU];
            LOCK1: gnt[M_DBG] = req[M_DBG];
            default: begin
                if (req == 2'b11) begin
                    // Tie goes to whichever master did not win last time.
                    gnt = (last_gnt == M_CPU) ? 2'b10 : 2'b01;
                end else begin
                    gnt = req;
                end
            end
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one synchronous data-RAM port between the CPU data port (m0) and the
// debug/loader master (m1): round-robin arbitration, a bounded lock for atomic
// sequences, and routing of the 1-cycle-latency read data back to the reader.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   mN_req/addr/wdata/we/be/lock request side of master N (N = 0, 1)
//   mN_gnt                       request accepted this cycle (combinational)
//   mN_rvalid, mN_rdata          read response for master N, one cycle after its read
//   mem_addr/wdata/we/be         RAM command, all zero when no transfer
//   mem_rdata                    RAM read data, valid one cycle after the address
//
// State   | meaning
// --------+---------------------------------------------------------------
// ARB     | free arbitration, round-robin on ties
// LOCK0   | m0 owns the port; m1 stalls until unlock, m0 idle, or hold limit
// LOCK1   | m1 owns the port; m0 stalls until unlock, m1 idle, or hold limit
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic                m0_we,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic                m0_lock,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,

    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic                m1_we,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic                m1_lock,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,

    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

    arb_state_t       state, state_nxt;
    logic             last_gnt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt, hold_inc;
    logic             resp_v, resp_id;

    logic [1:0] req, gnt;
    logic       xfer, xfer_id, xfer_we, xfer_lock;
    logic       own_id, own_req, own_lock, other_req;

    // Masking requests during reset keeps every grant and RAM strobe low
    // for the whole reset cycle, not just after the registers clear.
    assign req = rst ? 2'b00 : {m1_req, m0_req};

    arb_rr_pick2 u_pick (
        .req      (req),
        .last_gnt (last_gnt),
        .state    (state),
        .gnt      (gnt)
    );

    assign m0_gnt    = gnt[M_CPU];
    assign m1_gnt    = gnt[M_DBG];
    assign xfer      = |gnt;
    assign xfer_id   = gnt[M_DBG];
    assign xfer_we   = gnt[M_DBG] ? m1_we   : m0_we;
    assign xfer_lock = gnt[M_DBG] ? m1_lock : m0_lock;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_be    = '0;
        if (gnt[M_CPU]) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_we    = m0_we;
            mem_be    = m0_be;
        end else if (gnt[M_DBG]) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_we    = m1_we;
            mem_be    = m1_be;
        end
    end

    // Owner-relative view of the lock so LOCK0 and LOCK1 share one exit rule.
    assign own_id    = (state == LOCK1);
    assign own_req   = own_id ? req[M_DBG] : req[M_CPU];
    assign own_lock  = own_id ? m1_lock    : m0_lock;
    assign other_req = own_id ? req[M_CPU] : req[M_DBG];
    assign hold_inc  = other_req ? hold_cnt + 1'b1 : hold_cnt;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            LOCK0, LOCK1: begin
                if (!own_req) begin
                    state_nxt = ARB;
                    hold_nxt  = '0;
                end else if (!own_lock || hold_inc == HOLD_LIMIT) begin
                    // The owner is granted this cycle. Because last_gnt follows that
                    // grant, a forced exit hands the next tie to the starved master.
                    state_nxt = ARB;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt  = hold_inc;
                end
            end
            default: begin
                state_nxt = ARB;
                if (xfer && xfer_lock) begin
                    state_nxt = xfer_id ? LOCK1 : LOCK0;
                    hold_nxt  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            last_gnt <= M_DBG;
            hold_cnt <= '0;
            resp_v   <= 1'b0;
            resp_id  <= M_CPU;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            resp_v   <= xfer & ~xfer_we;
            resp_id  <= xfer_id;
            if (xfer) begin
                last_gnt <= xfer_id;
            end
        end
    end

    // A response pending when reset arrives is dropped, not delivered.
    assign m0_rvalid = ~rst & resp_v & (resp_id == M_CPU);
    assign m1_rvalid = ~rst & resp_v & (resp_id == M_DBG);
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
